// File: rtl/conv_encoder.sv
// Rate-1/2, constraint-length-4 convolutional encoder with a zero tail.
// Takes a frame of payload bits over valid/ready and emits one registered
// {y1,y0} symbol per bit, then 3 tail symbols that flush the memory to zero.
module conv_encoder #(
  parameter logic [3:0]  G0    = 4'b1111,
  parameter logic [3:0]  G1    = 4'b1011,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       sym_out,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             sym_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_TWO = LEN_W'(2);

  state_t           state;
  logic [2:0]       sr;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;

  logic       slot_free;
  logic       accept;
  logic       tail_go;
  logic       enc_fire;
  logic       enc_d;
  logic       start_ok;
  logic       last_hs;
  logic [3:0] taps;
  logic [1:0] enc_sym;

  // Handshake qualification and the encoder tap network.
  always_comb begin
    slot_free = !sym_valid || sym_ready;
    in_ready  = (state == DATA) && slot_free;
    accept    = in_ready && in_valid;
    tail_go   = (state == TAIL) && slot_free;
    enc_fire  = accept || tail_go;
    enc_d     = accept ? in_bit : 1'b0;
    taps      = {enc_d, sr[0], sr[1], sr[2]};
    enc_sym   = {^(G1 & taps), ^(G0 & taps)};
    last_hs   = sym_valid && sym_ready && sym_last;
    // The FSM returns to IDLE when the last tail symbol is loaded, but a new
    // frame must wait until that symbol has actually left (busy dropped).
    start_ok  = (state == IDLE) && !busy && start;
  end

  // Frame FSM, shift register and registered symbol output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= '0;
      count     <= '0;
      len_q     <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      sr        <= '0;
      count     <= '0;
      len_q     <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_hs;

      if (start_ok) begin
        busy <= 1'b1;
      end else if (last_hs) begin
        busy <= 1'b0;
      end

      if (slot_free) begin
        sym_valid <= enc_fire;
        sym_last  <= tail_go && (count == CNT_TWO);
        if (enc_fire) begin
          sym_out <= enc_sym;
        end
      end

      if (enc_fire) begin
        sr <= {sr[1], sr[0], enc_d};
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q <= frame_len;
            count <= '0;
            state <= (frame_len == '0) ? TAIL : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            if (count == len_q - CNT_ONE) begin
              count <= '0;
              state <= TAIL;
            end else begin
              count <= count + CNT_ONE;
            end
          end
        end
        TAIL: begin
          if (tail_go) begin
            if (count == CNT_TWO) begin
              count <= '0;
              state <= IDLE;
            end else begin
              count <= count + CNT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: hand-computed symbol streams, stalls,
// reset/enable aborts, ignored and back-to-back starts.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       start;
  logic [7:0] frame_len;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       sym_ready;
  logic       sym_last;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected stream for payload 1,0,1,1: 11,01,00,01,10,00,11 (symbol i at [2i+:2]).
  localparam logic [15:0] EXP_1011 = 16'h3247;
  localparam logic [7:0]  BITS_1011 = 8'h0D;

  conv_encoder #(.G0(4'b1111), .G1(4'b1011), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start),
    .frame_len(frame_len), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .sym_out(sym_out), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_last(sym_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; drives start now. Ends at the negedge of the done cycle.
  task automatic run_frame(input int len, input logic [7:0] bits,
                           input logic [15:0] exp_syms, input bit stall, input bit inject);
    int nsym;
    int bi;
    int si;
    int cyc;
    logic [3:0] pat;
    logic       held;
    logic [3:0] held_val;
    nsym = len + 3;
    bi = 0;
    si = 0;
    cyc = 0;
    pat = 4'b1001;
    held = 1'b0;
    held_val = '0;
    start = 1'b1;
    frame_len = 8'(len);
    in_valid = 1'b0;
    sym_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_len = 8'd5;
    #1;
    check_eq("busy_after_start", {31'b0, busy}, 32'd1);
    while (si < nsym && cyc < 200) begin
      sym_ready = stall ? pat[cyc % 4] : 1'b1;
      in_valid  = (bi < len);
      in_bit    = (bi < 8) ? bits[bi] : 1'b0;
      start     = inject && (cyc == 2);
      #1;
      if (held) check_eq("stall_stable", {28'b0, sym_valid, sym_last, sym_out}, {28'b0, held_val});
      if (sym_valid && !sym_ready) begin
        check_eq("in_ready_full", {31'b0, in_ready}, 32'd0);
        held = 1'b1;
        held_val = {sym_valid, sym_last, sym_out};
      end else begin
        held = 1'b0;
      end
      if (len == 0) check_eq("in_ready_len0", {31'b0, in_ready}, 32'd0);
      check_eq("no_early_done", {31'b0, done}, 32'd0);
      if (in_valid && in_ready) bi++;
      if (sym_valid && sym_ready) begin
        check_eq($sformatf("sym%0d", si), {30'b0, sym_out}, {30'b0, exp_syms[2*si +: 2]});
        check_eq($sformatf("last%0d", si), {31'b0, sym_last}, {31'b0, (si == nsym - 1)});
        si++;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check_eq("sym_count", si, nsym);
    in_valid = 1'b0;
    sym_ready = 1'b1;
    #1;
    check_eq("done_pulse", {31'b0, done}, 32'd1);
    check_eq("busy_end", {31'b0, busy}, 32'd0);
    check_eq("valid_end", {31'b0, sym_valid}, 32'd0);
    check_eq("sr_zero", {29'b0, dut.sr}, 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_valid"}, {31'b0, sym_valid}, 32'd0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd0);
    check_eq({tag, "_last_out"}, {29'b0, sym_last, sym_out}, 32'd0);
  endtask

  initial begin
    int acc;
    int guard;
    rst = 1'b0;
    enable = 1'b1;
    start = 1'b0;
    frame_len = '0;
    in_bit = 1'b0;
    in_valid = 1'b0;
    sym_ready = 1'b1;
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame, free-flowing output.
    run_frame(4, BITS_1011, EXP_1011, 1'b0, 1'b0);
    @(negedge clk);
    // Empty frame: tail only.
    run_frame(0, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    // Stalled output with an ignored start, then a start in the done cycle.
    run_frame(4, BITS_1011, EXP_1011, 1'b1, 1'b1);
    run_frame(4, BITS_1011, EXP_1011, 1'b0, 1'b1);
    @(negedge clk);

    // Asynchronous reset after two accepted bits.
    start = 1'b1;
    frame_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < 2 && guard < 20) begin
      in_valid = 1'b1;
      in_bit = BITS_1011[acc];
      #1;
      if (in_ready) acc++;
      @(negedge clk);
      guard++;
    end
    check_eq("two_bits_accepted", acc, 2);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_cleared("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(4, BITS_1011, EXP_1011, 1'b0, 1'b0);
    @(negedge clk);

    // Enable dropped for one cycle mid-TAIL.
    start = 1'b1;
    frame_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check_eq("tail_valid_before_drop", {31'b0, sym_valid}, 32'd1);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    #1;
    check_cleared("en_drop");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_done_after_drop", {30'b0, done, sym_valid}, 32'd0);
    end
    run_frame(4, BITS_1011, EXP_1011, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2, constraint-length-4 (3-bit memory) convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder path: ACS, traceback and the tbu unit.
- It accepts a frame of payload bits over a valid/ready handshake and emits one 2-bit coded symbol per bit.
- It appends 3 zero tail bits so that every frame ends in state 0, which the decoder's traceback start condition requires.
- Output is a registered symbol stream with backpressure.

Parameters:
- G0, 4'b1111, generator tap vector for y0.
- G1, 4'b1011, generator tap vector for y1.
- LEN_W, 8, width of the frame length input and of the bit counter.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  asynchronous active-low reset.
- enable  input  1  synchronous block enable; low means clear to idle.
- start  input  1  single-cycle frame start request.
- frame_len  input  LEN_W  payload bit count, latched when start is accepted.
- in_bit  input  1  payload bit.
- in_valid  input  1  payload bit valid.
- in_ready  output  1  encoder can accept in_bit this cycle.
- sym_out  output  2  coded symbol {y1,y0}.
- sym_valid  output  1  sym_out holds a symbol.
- sym_ready  input  1  downstream accepts sym_out.
- sym_last  output  1  qualifies the final tail symbol of a frame.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when the last symbol is consumed.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, sr[2:0]=0, count=0, len_q=0.
  - sym_out=0, sym_valid=0, sym_last=0, done=0, busy=0, in_ready=0.
  - Reset mid-frame aborts immediately; any partial frame is discarded.
- enable=0 (synchronous, takes priority over every other input): same clear as reset on the next edge.
- Memory: sr[0] holds the most recent previous bit, sr[2] the oldest.
- Tap vector for input bit d: T={d,sr[0],sr[1],sr[2]}, with index 3 = d.
  - y0 = XOR-reduce(G0 & T).
  - y1 = XOR-reduce(G1 & T).
- When a bit d is encoded: sr <= {sr[1],sr[0],d}.
- Output register slot is free when sym_valid=0 or sym_ready=1 (pipelined; no bubble under continuous ready).
- FSM states: IDLE, DATA, TAIL.
  - IDLE: start=1 latches len_q=frame_len and sets count=0.
    - If frame_len=0, go to TAIL; otherwise go to DATA.
    - start is ignored in any other state.
  - DATA: in_ready = slot free.
    - On in_valid and in_ready, encode in_bit into the output register, then count++.
    - When count reaches len_q-1 on an accepted bit, go to TAIL with count=0.
  - TAIL: whenever the slot is free, encode d=0, then count++.
    - The third tail symbol (count=2) sets sym_last=1 and moves to IDLE.
- Latency: a symbol is visible on sym_out exactly 1 cycle after its bit is accepted (or after its tail cycle).
- sym_out, sym_valid and sym_last must hold stable while sym_valid=1 and sym_ready=0.
- done pulses for 1 cycle in the cycle after the symbol with sym_last=1 handshakes.
- busy=1 from the cycle after start acceptance until the last symbol is consumed; it stays high while the final symbol is stalled.
- A start that coincides with the done cycle is accepted: the FSM is in IDLE once sym_last has left.
- Symbols per frame = frame_len+3.
- The count register width is LEN_W; frame_len=2^LEN_W-1 must work without wrap error.
- After the last tail symbol, sr=3'b000.

Test Plan:
- Frame of bits 1,0,1,1 (frame_len=4), sym_ready held 1:
  - sym_out sequence 11,01,00,01,10,00,11.
  - sym_last only on the 7th symbol, done one cycle later, sr=0.
- frame_len=0, start pulse:
  - three symbols 00,00,00 with sym_last on the third.
  - in_ready never asserts.
- Same 4-bit frame with sym_ready toggling 1,0,0,1 repeatedly:
  - identical symbol sequence, no drops or duplicates.
  - sym_out stable during stalls; in_ready low whenever the slot is full.
- Assert rst=0 after 2 accepted bits:
  - all outputs go to their reset values immediately.
  - A new frame 1,0,1,1 produces the same symbols as the first scenario.
- Drop enable for 1 cycle mid-TAIL:
  - busy=0 and sym_valid=0 on the next edge; no done pulse.
  - A subsequent start behaves as from reset.
- start pulsed while busy:
  - ignored; frame_len change has no effect.
  - A back-to-back start in the done cycle begins a second frame, and both frames are encoded correctly.
